// File: rtl/l2_port_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | l2_port_arbiter_pkg: shared states, statistics width and address split     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package l2_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_L2 = 3'd2,
    ST_BI_WAIT = 3'd3,
    ST_RESPOND = 3'd4
  } arb_state_t;

  localparam int c_CNT_WIDTH = 20;

  // Address split shared with the L1/L2 cache models: | tag | set index | line offset |
  localparam int c_LINE_OFFSET_W = 6;
  localparam int c_SET_INDEX_W   = 10;
  localparam int c_TAG_LSB       = c_LINE_OFFSET_W + c_SET_INDEX_W;

endpackage
`default_nettype wire

// File: rtl/l2_port_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_pick: combinational round-robin selector, first request after last_grant |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rr_pick #(
  parameter int NUM_CORES = 4,
  parameter int GRANT_W   = 2
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [GRANT_W-1:0]   last_grant,
  output logic                 any,
  output logic [GRANT_W-1:0]   grant_id
);

  int w_dist;
  int w_best;

  // Distance 0 is the core right after last_grant; the smallest distance wins.
  always_comb begin
    any      = 1'b0;
    grant_id = last_grant;
    w_dist   = 0;
    w_best   = NUM_CORES;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_dist = (i + NUM_CORES - 1 - int'(last_grant)) % NUM_CORES;
      if (req[i] && (w_dist < w_best)) begin
        w_best   = w_dist;
        grant_id = GRANT_W'(i);
        any      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/l2_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | l2_port_arbiter: round-robin sharing of the L2 find port among L1 caches   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module l2_port_arbiter
  import l2_port_arbiter_pkg::*;
#(
  parameter int NUM_CORES      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int CNT_WIDTH      = c_CNT_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CORES-1:0]            core_req,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr,
  output logic [NUM_CORES-1:0]            core_ack,
  output logic                            core_hit,
  output logic                            core_err,
  output logic                            l2_find_start,
  output logic [ADDR_WIDTH-1:0]           l2_addr,
  input  logic                            l2_done,
  input  logic                            l2_hit,
  input  logic                            l2_back_inval,
  input  logic [ADDR_WIDTH-1:0]           l2_back_inval_addr,
  output logic [NUM_CORES-1:0]            bi_valid,
  output logic [ADDR_WIDTH-1:0]           bi_addr,
  input  logic [NUM_CORES-1:0]            l1_bi_done,
  output logic [CNT_WIDTH-1:0]            l2_hit_count,
  output logic [CNT_WIDTH-1:0]            l2_miss_count,
  output logic [CNT_WIDTH-1:0]            timeout_count
);

  localparam int             c_GRANT_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [7:0]     c_TIMEOUT = TIMEOUT_CYCLES[7:0];
  localparam logic [c_GRANT_W-1:0] c_LAST_RST = c_GRANT_W'(NUM_CORES - 1);

  arb_state_t                r_state, w_state_nxt;
  logic [c_GRANT_W-1:0]      r_grant_id, w_grant_id_nxt;
  logic [c_GRANT_W-1:0]      r_last_grant, w_last_grant_nxt;
  logic                      r_hit, w_hit_nxt;
  logic                      r_err, w_err_nxt;
  logic [7:0]                r_wdog, w_wdog_nxt;
  logic [NUM_CORES-1:0]      r_bi_pending, w_bi_pending_nxt;

  logic                      w_find_start_nxt;
  logic [ADDR_WIDTH-1:0]     w_l2_addr_nxt;
  logic [NUM_CORES-1:0]      w_core_ack_nxt;
  logic                      w_core_hit_nxt;
  logic                      w_core_err_nxt;
  logic [NUM_CORES-1:0]      w_bi_valid_nxt;
  logic [ADDR_WIDTH-1:0]     w_bi_addr_nxt;
  logic [CNT_WIDTH-1:0]      w_hit_cnt_nxt, w_miss_cnt_nxt, w_to_cnt_nxt;
  logic                      w_to_respond;

  logic                      w_any;
  logic [c_GRANT_W-1:0]      w_pick_id;
  logic [ADDR_WIDTH-1:0]     w_addr_arr [NUM_CORES];

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_addr_unpack
    assign w_addr_arr[g] = core_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  rr_pick #(
    .NUM_CORES (NUM_CORES),
    .GRANT_W   (c_GRANT_W)
  ) u_rr_pick (
    .req        (core_req),
    .last_grant (r_last_grant),
    .any        (w_any),
    .grant_id   (w_pick_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_grant_id    <= '0;
      r_last_grant  <= c_LAST_RST;
      r_hit         <= 1'b0;
      r_err         <= 1'b0;
      r_wdog        <= '0;
      r_bi_pending  <= '0;
      l2_find_start <= 1'b0;
      l2_addr       <= '0;
      core_ack      <= '0;
      core_hit      <= 1'b0;
      core_err      <= 1'b0;
      bi_valid      <= '0;
      bi_addr       <= '0;
      l2_hit_count  <= '0;
      l2_miss_count <= '0;
      timeout_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_hit         <= w_hit_nxt;
      r_err         <= w_err_nxt;
      r_wdog        <= w_wdog_nxt;
      r_bi_pending  <= w_bi_pending_nxt;
      l2_find_start <= w_find_start_nxt;
      l2_addr       <= w_l2_addr_nxt;
      core_ack      <= w_core_ack_nxt;
      core_hit      <= w_core_hit_nxt;
      core_err      <= w_core_err_nxt;
      bi_valid      <= w_bi_valid_nxt;
      bi_addr       <= w_bi_addr_nxt;
      l2_hit_count  <= w_hit_cnt_nxt;
      l2_miss_count <= w_miss_cnt_nxt;
      timeout_count <= w_to_cnt_nxt;
    end
  end

  // Outputs are registered, so pulse outputs are set on the transition into their state.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_id_nxt   = r_grant_id;
    w_last_grant_nxt = r_last_grant;
    w_hit_nxt        = r_hit;
    w_err_nxt        = r_err;
    w_wdog_nxt       = r_wdog;
    w_bi_pending_nxt = r_bi_pending;
    w_find_start_nxt = 1'b0;
    w_l2_addr_nxt    = l2_addr;
    w_core_ack_nxt   = '0;
    w_core_hit_nxt   = 1'b0;
    w_core_err_nxt   = 1'b0;
    w_bi_valid_nxt   = bi_valid;
    w_bi_addr_nxt    = bi_addr;
    w_hit_cnt_nxt    = l2_hit_count;
    w_miss_cnt_nxt   = l2_miss_count;
    w_to_cnt_nxt     = timeout_count;
    w_to_respond     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant_id_nxt   = w_pick_id;
          w_l2_addr_nxt    = w_addr_arr[w_pick_id];
          w_find_start_nxt = 1'b1;
          w_state_nxt      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_wdog_nxt  = '0;
        w_state_nxt = ST_WAIT_L2;
      end
      ST_WAIT_L2: begin
        if (l2_done) begin
          w_hit_nxt = l2_hit;
          if (l2_back_inval) begin
            w_bi_addr_nxt    = l2_back_inval_addr;
            w_bi_pending_nxt = '1;
            w_bi_valid_nxt   = '1;
            w_wdog_nxt       = '0;
            w_state_nxt      = ST_BI_WAIT;
          end else begin
            w_to_respond = 1'b1;
          end
        end else if (r_wdog == c_TIMEOUT) begin
          w_err_nxt    = 1'b1;
          w_hit_nxt    = 1'b0;
          w_to_respond = 1'b1;
        end else begin
          w_wdog_nxt = r_wdog + 8'd1;
        end
      end
      ST_BI_WAIT: begin
        w_bi_pending_nxt = r_bi_pending & ~l1_bi_done;
        w_bi_valid_nxt   = bi_valid & ~l1_bi_done;
        if (w_bi_pending_nxt == '0) begin
          w_to_respond = 1'b1;
        end else if (r_wdog == c_TIMEOUT) begin
          w_bi_valid_nxt   = '0;
          w_bi_pending_nxt = '0;
          w_err_nxt        = 1'b1;
          w_to_respond     = 1'b1;
        end else begin
          w_wdog_nxt = r_wdog + 8'd1;
        end
      end
      ST_RESPOND: begin
        w_last_grant_nxt = r_grant_id;
        if (r_err) begin
          if (timeout_count != '1) w_to_cnt_nxt = timeout_count + CNT_WIDTH'(1);
        end else if (r_hit) begin
          if (l2_hit_count != '1) w_hit_cnt_nxt = l2_hit_count + CNT_WIDTH'(1);
        end else begin
          if (l2_miss_count != '1) w_miss_cnt_nxt = l2_miss_count + CNT_WIDTH'(1);
        end
        w_err_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_to_respond) begin
      w_state_nxt    = ST_RESPOND;
      w_core_ack_nxt = NUM_CORES'(1) << r_grant_id;
      w_core_hit_nxt = w_hit_nxt;
      w_core_err_nxt = w_err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l2_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_l2_port_arbiter: directed scoreboard bench for l2_port_arbiter          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_l2_port_arbiter;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int CW = 20;
  localparam int TO = 255;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NC-1:0]   core_req = '0;
  logic [NC*AW-1:0] core_addr = '0;
  logic [NC-1:0]   core_ack;
  logic            core_hit, core_err, l2_find_start;
  logic [AW-1:0]   l2_addr, bi_addr;
  logic            l2_done = 1'b0, l2_hit = 1'b0, l2_back_inval = 1'b0;
  logic [AW-1:0]   l2_back_inval_addr = '0;
  logic [NC-1:0]   bi_valid;
  logic [NC-1:0]   l1_bi_done = '0;
  logic [CW-1:0]   l2_hit_count, l2_miss_count, timeout_count;

  l2_port_arbiter #(
    .NUM_CORES(NC), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .core_req(core_req), .core_addr(core_addr),
    .core_ack(core_ack), .core_hit(core_hit), .core_err(core_err),
    .l2_find_start(l2_find_start), .l2_addr(l2_addr), .l2_done(l2_done),
    .l2_hit(l2_hit), .l2_back_inval(l2_back_inval),
    .l2_back_inval_addr(l2_back_inval_addr), .bi_valid(bi_valid),
    .bi_addr(bi_addr), .l1_bi_done(l1_bi_done), .l2_hit_count(l2_hit_count),
    .l2_miss_count(l2_miss_count), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NC-1:0] ack;
    logic          hit;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            checks = 0;
  int            failures = 0;
  int            fs_count = 0;

  // L2 model configuration; delay 0 means the lookup never completes
  int            l2_delay_cfg = 1;
  logic          l2_hit_cfg = 1'b0;
  logic          l2_bi_cfg = 1'b0;
  logic [AW-1:0] l2_bi_addr_cfg = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic set_addr(input int core, input logic [AW-1:0] a);
    core_addr[core*AW +: AW] = a;
  endtask

  task automatic push(input logic [NC-1:0] ack, input logic hit, input logic err,
                      input logic [AW-1:0] a);
    exp_t e;
    e.ack = ack; e.hit = hit; e.err = err;
    exp_q.push_back(e);
    exp_addr_q.push_back(a);
  endtask

  task automatic wait_ack(input string name, input int budget, output int lat);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (core_ack != '0) break;
      if (lat >= budget) begin
        checks++;
        failures++;
        $display("FAIL %s_no_ack actual=none required=ack_within_%0d_cycles", name, budget);
        break;
      end
    end
  endtask

  task automatic wait_bi_set(input string name);
    int n = 0;
    while (bi_valid != '1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(bi_valid), 32'hF);
  endtask

  // L2 responder: answers a find_start after l2_delay_cfg cycles with a one-cycle l2_done
  initial begin
    int  l2_wait = 0;
    bit  l2_pend = 0;
    forever begin
      @(negedge clk);
      l2_done = 1'b0;
      l2_hit = 1'b0;
      l2_back_inval = 1'b0;
      if (!rst_n) begin
        l2_pend = 0;
      end else if (l2_pend) begin
        l2_wait--;
        if (l2_wait == 0) begin
          l2_done = 1'b1;
          l2_hit = l2_hit_cfg;
          l2_back_inval = l2_bi_cfg;
          l2_back_inval_addr = l2_bi_addr_cfg;
          l2_pend = 0;
        end
      end else if (l2_find_start && l2_delay_cfg > 0) begin
        l2_pend = 1;
        l2_wait = l2_delay_cfg;
      end
    end
  end

  // Monitor: checks every find_start address and every ack against the scoreboard
  initial begin
    exp_t          e;
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (l2_find_start) begin
          fs_count++;
          if (exp_addr_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_find_start actual=0x%0h required=none", l2_addr);
          end else begin
            a = exp_addr_q.pop_front();
            chk("l2_addr", l2_addr, a);
          end
        end
        if (core_ack != '0) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_ack actual=0x%0h required=none", core_ack);
          end else begin
            e = exp_q.pop_front();
            chk("ack_vector", 32'(core_ack), 32'(e.ack));
            chk("ack_hit", 32'(core_hit), 32'(e.hit));
            chk("ack_err", 32'(core_err), 32'(e.err));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat;
    int fs0;
    logic [NC-1:0] pats [4];
    logic [NC-1:0] vexp [4];

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_core_ack", 32'(core_ack), 0);
    chk("rst_bi_valid", 32'(bi_valid), 0);
    chk("rst_find_start", 32'(l2_find_start), 0);
    chk("rst_counters", 32'(l2_hit_count | l2_miss_count | timeout_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single hit, L2 answers two cycles after find_start
    l2_delay_cfg = 2; l2_hit_cfg = 1'b1;
    set_addr(0, 32'h0000_1230);
    push(4'b0001, 1'b1, 1'b0, 32'h0000_1230);
    fs0 = fs_count;
    core_req = 4'b0001;
    wait_ack("t1", 20, lat);
    core_req = '0;
    chk("t1_latency", lat, 4);
    chk("t1_find_start_pulses", fs_count - fs0, 1);
    repeat (2) @(negedge clk);
    chk("t1_hit_count", 32'(l2_hit_count), 1);
    chk("t1_miss_count", 32'(l2_miss_count), 0);

    // 2: all cores requesting, round-robin 0,1,2,3,0 with misses
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    l2_delay_cfg = 1; l2_hit_cfg = 1'b0;
    for (int i = 0; i < NC; i++) set_addr(i, 32'h100 * (i + 1));
    push(4'b0001, 1'b0, 1'b0, 32'h100);
    push(4'b0010, 1'b0, 1'b0, 32'h200);
    push(4'b0100, 1'b0, 1'b0, 32'h300);
    push(4'b1000, 1'b0, 1'b0, 32'h400);
    push(4'b0001, 1'b0, 1'b0, 32'h100);
    core_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack("t2", 20, lat);
      if (k == 4) core_req = '0;
      chk("t2_latency", lat, (k == 0) ? 3 : 4);
    end
    repeat (2) @(negedge clk);
    chk("t2_miss_count", 32'(l2_miss_count), 5);

    // 3: back-invalidation on core 2, dones from cores 0,3(+stale 0),1,2
    l2_bi_cfg = 1'b1; l2_bi_addr_cfg = 32'h0000_ABC0;
    set_addr(2, 32'h0000_2000);
    push(4'b0100, 1'b0, 1'b0, 32'h0000_2000);
    core_req = 4'b0100;
    wait_bi_set("t3_bi_valid_set");
    l2_bi_cfg = 1'b0;
    chk("t3_bi_addr", bi_addr, 32'h0000_ABC0);
    pats[0] = 4'b0001; pats[1] = 4'b1001; pats[2] = 4'b0010; pats[3] = 4'b0100;
    vexp[0] = 4'b1110; vexp[1] = 4'b0110; vexp[2] = 4'b0100; vexp[3] = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      l1_bi_done = pats[i];
      @(negedge clk);
      l1_bi_done = '0;
      chk("t3_bi_valid", 32'(bi_valid), 32'(vexp[i]));
      if (i < 3) begin
        chk("t3_no_early_ack", 32'(core_ack), 0);
        @(negedge clk);
      end else begin
        chk("t3_ack_after_last_done", 32'(core_ack), 32'h4);
        core_req = '0;
      end
    end
    repeat (2) @(negedge clk);
    chk("t3_miss_count", 32'(l2_miss_count), 6);

    // 4: no l2_done -> watchdog error, then a normal hit
    l2_delay_cfg = 0;
    set_addr(1, 32'h0000_3000);
    push(4'b0010, 1'b0, 1'b1, 32'h0000_3000);
    core_req = 4'b0010;
    wait_ack("t4", 400, lat);
    core_req = '0;
    chk("t4_timeout_latency", lat, TO + 3);
    repeat (2) @(negedge clk);
    chk("t4_timeout_count", 32'(timeout_count), 1);
    chk("t4_miss_count", 32'(l2_miss_count), 6);
    l2_delay_cfg = 1; l2_hit_cfg = 1'b1;
    set_addr(3, 32'h0000_4000);
    push(4'b1000, 1'b1, 1'b0, 32'h0000_4000);
    core_req = 4'b1000;
    wait_ack("t4b", 20, lat);
    core_req = '0;
    chk("t4b_latency", lat, 3);
    repeat (2) @(negedge clk);
    chk("t4b_hit_count", 32'(l2_hit_count), 1);

    // 5: reset during BI_WAIT, then core 0 is granted before core 2
    l2_hit_cfg = 1'b0;
    set_addr(1, 32'h0000_0210);
    push(4'b0010, 1'b0, 1'b0, 32'h0000_0210);
    core_req = 4'b0010;
    wait_ack("t5a", 20, lat);
    core_req = '0;
    @(negedge clk);
    l2_bi_cfg = 1'b1; l2_bi_addr_cfg = 32'h0000_DEC0;
    set_addr(2, 32'h0000_5000);
    exp_addr_q.push_back(32'h0000_5000);
    core_req = 4'b0100;
    wait_bi_set("t5_bi_valid_set");
    l2_bi_cfg = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_async_bi_valid", 32'(bi_valid), 0);
    chk("t5_async_core_ack", 32'(core_ack), 0);
    chk("t5_async_counters", 32'(l2_hit_count | l2_miss_count | timeout_count), 0);
    core_req = '0;
    @(negedge clk);
    set_addr(0, 32'h0000_6000);
    push(4'b0001, 1'b0, 1'b0, 32'h0000_6000);
    push(4'b0100, 1'b0, 1'b0, 32'h0000_5000);
    rst_n = 1'b1;
    core_req = 4'b0101;
    wait_ack("t5b", 20, lat);
    chk("t5b_latency", lat, 3);
    wait_ack("t5c", 20, lat);
    core_req = '0;
    repeat (2) @(negedge clk);
    chk("t5_miss_count", 32'(l2_miss_count), 2);

    // 6: hit counter saturates at all ones
    force dut.l2_hit_count = '1;
    #1;
    release dut.l2_hit_count;
    l2_hit_cfg = 1'b1;
    set_addr(1, 32'h0000_7000);
    push(4'b0010, 1'b1, 1'b0, 32'h0000_7000);
    @(negedge clk);
    core_req = 4'b0010;
    wait_ack("t6", 20, lat);
    core_req = '0;
    repeat (2) @(negedge clk);
    chk("t6_hit_saturated", 32'(l2_hit_count), 32'hF_FFFF);
    chk("t6_miss_count", 32'(l2_miss_count), 2);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("addr_queue_empty", exp_addr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
